// File: rtl/continuous_monitoring_system_pkg.sv
`default_nettype none
// ============================================================================
// Module      : continuous_monitoring_system_pkg
// Description : Shared constants and types for the continuous monitoring system.
// Revision    : 1.0 - parametrised performance event counter bank support
// ============================================================================
package continuous_monitoring_system_pkg;

    localparam int NO_OF_PERFORMANCE_EVENTS            = 3;
    localparam int PERFORMANCE_EVENT_MOD_COUNTER_WIDTH = 8;
    localparam int PERFORMANCE_EVENT_INC_WIDTH         = 1;

    typedef logic [PERFORMANCE_EVENT_MOD_COUNTER_WIDTH-1:0] perf_counter_t;

endpackage
`default_nettype wire

// File: rtl/perf_counter_channel.sv
`default_nettype none
// ============================================================================
// Module      : perf_counter_channel
// Description : One event counter: add, wrap/saturate, sticky overflow, load on
//               snapshot. Optional threshold detect via PERF_COUNTER_THRESHOLD_IRQ_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module perf_counter_channel
    import continuous_monitoring_system_pkg::*;
#(
    parameter int COUNTER_WIDTH = PERFORMANCE_EVENT_MOD_COUNTER_WIDTH,
    parameter int INC_WIDTH     = PERFORMANCE_EVENT_INC_WIDTH,
    parameter int SATURATE      = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [INC_WIDTH-1:0]     inc,
    input  logic                     clear,
    input  logic                     load,
    output logic [COUNTER_WIDTH-1:0] count,
    output logic                     overflow
`ifdef PERF_COUNTER_THRESHOLD_IRQ_EN
    ,
    input  logic [COUNTER_WIDTH-1:0] threshold,
    output logic                     threshold_hit
`endif
);

    generate
        if (INC_WIDTH > COUNTER_WIDTH) begin : g_width_check
            $error("perf_counter_channel: INC_WIDTH must not exceed COUNTER_WIDTH");
        end
    endgenerate

    logic [COUNTER_WIDTH-1:0] r_count;
    logic                     r_overflow;
    logic [COUNTER_WIDTH-1:0] w_base;
    logic [COUNTER_WIDTH:0]   w_sum;
    logic                     w_carry;
    logic [COUNTER_WIDTH-1:0] w_next;

    // A snapshot restarts the interval from zero but still keeps this cycle's increment.
    always_comb begin
        w_base  = load ? '0 : r_count;
        w_sum   = {1'b0, w_base} + {{(COUNTER_WIDTH + 1 - INC_WIDTH){1'b0}}, inc};
        w_carry = w_sum[COUNTER_WIDTH];
        if (w_carry && (SATURATE != 0)) begin
            w_next = '1;
        end else begin
            w_next = w_sum[COUNTER_WIDTH-1:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else if (clear) begin
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_count    <= w_next;
            r_overflow <= (r_overflow & ~load) | w_carry;
        end
    end

    assign count    = r_count;
    assign overflow = r_overflow;

`ifdef PERF_COUNTER_THRESHOLD_IRQ_EN
    logic r_hit;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hit <= 1'b0;
        end else begin
            r_hit <= !clear && !load && (threshold != '0) &&
                     (r_count < threshold) && (w_next >= threshold);
        end
    end

    assign threshold_hit = r_hit;
`endif

endmodule
`default_nettype wire

// File: rtl/perf_event_counter_bank.sv
`default_nettype none
// ============================================================================
// Module      : perf_event_counter_bank
// Description : N event counters with atomic snapshot-and-clear handoff.
//               Optional threshold pulses via PERF_COUNTER_THRESHOLD_IRQ_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module perf_event_counter_bank
    import continuous_monitoring_system_pkg::*;
#(
    parameter int NO_OF_EVENTS  = NO_OF_PERFORMANCE_EVENTS,
    parameter int COUNTER_WIDTH = PERFORMANCE_EVENT_MOD_COUNTER_WIDTH,
    parameter int INC_WIDTH     = PERFORMANCE_EVENT_INC_WIDTH,
    parameter int SATURATE      = 0
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [NO_OF_EVENTS*INC_WIDTH-1:0] event_increments,
    input  logic [NO_OF_EVENTS-1:0]           enable_mask,
    input  logic                              clear,
    input  logic                              snapshot_req,
    input  logic                              snapshot_ready,
    output logic                              snapshot_valid,
    output logic                              snapshot_overrun,
    output logic [COUNTER_WIDTH-1:0]          counters [NO_OF_EVENTS],
    output logic [COUNTER_WIDTH-1:0]          snapshot [NO_OF_EVENTS],
    output logic [NO_OF_EVENTS-1:0]           overflow_flags,
    output logic [NO_OF_EVENTS-1:0]           snapshot_overflow
`ifdef PERF_COUNTER_THRESHOLD_IRQ_EN
    ,
    input  logic [COUNTER_WIDTH-1:0]          threshold,
    output logic [NO_OF_EVENTS-1:0]           threshold_hit
`endif
);

    logic                     w_accept;
    logic                     r_valid;
    logic                     r_overrun;
    logic [COUNTER_WIDTH-1:0] r_snapshot [NO_OF_EVENTS];
    logic [NO_OF_EVENTS-1:0]  r_snapshot_overflow;

    // Clear outranks a snapshot request, so a request in a clear cycle is simply dropped.
    assign w_accept = snapshot_req && !clear && (!r_valid || snapshot_ready);

    generate
        for (genvar gi = 0; gi < NO_OF_EVENTS; gi++) begin : g_channel
            logic [INC_WIDTH-1:0] w_inc;

            assign w_inc = enable_mask[gi] ? event_increments[gi*INC_WIDTH +: INC_WIDTH] : '0;

            perf_counter_channel #(
                .COUNTER_WIDTH (COUNTER_WIDTH),
                .INC_WIDTH     (INC_WIDTH),
                .SATURATE      (SATURATE)
            ) u_channel (
                .clk           (clk),
                .rst           (rst),
                .inc           (w_inc),
                .clear         (clear),
                .load          (w_accept),
                .count         (counters[gi]),
                .overflow      (overflow_flags[gi])
`ifdef PERF_COUNTER_THRESHOLD_IRQ_EN
                ,
                .threshold     (threshold),
                .threshold_hit (threshold_hit[gi])
`endif
            );
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid             <= 1'b0;
            r_overrun           <= 1'b0;
            r_snapshot_overflow <= '0;
            for (int i = 0; i < NO_OF_EVENTS; i++) begin
                r_snapshot[i] <= '0;
            end
        end else begin
            r_overrun <= snapshot_req && !clear && r_valid && !snapshot_ready;
            if (!clear) begin
                if (w_accept) begin
                    r_snapshot          <= counters;
                    r_snapshot_overflow <= overflow_flags;
                    r_valid             <= 1'b1;
                end else if (snapshot_ready) begin
                    r_valid <= 1'b0;
                end
            end
        end
    end

    assign snapshot_valid    = r_valid;
    assign snapshot_overrun  = r_overrun;
    assign snapshot          = r_snapshot;
    assign snapshot_overflow = r_snapshot_overflow;

endmodule
`default_nettype wire

// File: tb/tb_perf_event_counter_bank.sv
`default_nettype none
// ============================================================================
// Module      : tb_perf_event_counter_bank
// Description : Self-checking bench: one bitmap bank (8-bit) plus wrap and
//               saturate banks (4-bit, 3-bit increments) against a reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_perf_event_counter_bank;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] ev1;
    logic [8:0] ev3;
    logic [2:0] mask;
    logic       clear, req, ready;

    logic       v0, v1, v2, o0, o1, o2;
    logic [7:0] c0 [3];
    logic [7:0] s0 [3];
    logic [3:0] c1 [3];
    logic [3:0] s1 [3];
    logic [3:0] c2 [3];
    logic [3:0] s2 [3];
    logic [2:0] f0, f1, f2, sf0, sf1, sf2;
`ifdef PERF_COUNTER_THRESHOLD_IRQ_EN
    logic [7:0] thr;
    logic [3:0] thr4;
    logic [2:0] hit0, hit1, hit2;
    bit   [2:0] m_hit;
`endif

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model state, indexed [bank][channel]
    int   m_cnt  [3][3];
    int   m_snap [3][3];
    bit   [2:0] m_ovf [3];
    bit   [2:0] m_sovf [3];
    bit   m_valid [3];
    bit   m_ovr [3];
    int   m_thr = 5;
    int   cw_of [3] = '{8, 4, 4};
    bit   sat_of [3] = '{1'b0, 1'b0, 1'b1};

    always #5 clk = ~clk;

    perf_event_counter_bank #(.NO_OF_EVENTS(3), .COUNTER_WIDTH(8), .INC_WIDTH(1), .SATURATE(0)) u_dut0 (
        .clk(clk), .rst(rst), .event_increments(ev1), .enable_mask(mask), .clear(clear),
        .snapshot_req(req), .snapshot_ready(ready), .snapshot_valid(v0), .snapshot_overrun(o0),
        .counters(c0), .snapshot(s0), .overflow_flags(f0), .snapshot_overflow(sf0)
`ifdef PERF_COUNTER_THRESHOLD_IRQ_EN
        , .threshold(thr), .threshold_hit(hit0)
`endif
    );

    perf_event_counter_bank #(.NO_OF_EVENTS(3), .COUNTER_WIDTH(4), .INC_WIDTH(3), .SATURATE(0)) u_dut1 (
        .clk(clk), .rst(rst), .event_increments(ev3), .enable_mask(mask), .clear(clear),
        .snapshot_req(req), .snapshot_ready(ready), .snapshot_valid(v1), .snapshot_overrun(o1),
        .counters(c1), .snapshot(s1), .overflow_flags(f1), .snapshot_overflow(sf1)
`ifdef PERF_COUNTER_THRESHOLD_IRQ_EN
        , .threshold(thr4), .threshold_hit(hit1)
`endif
    );

    perf_event_counter_bank #(.NO_OF_EVENTS(3), .COUNTER_WIDTH(4), .INC_WIDTH(3), .SATURATE(1)) u_dut2 (
        .clk(clk), .rst(rst), .event_increments(ev3), .enable_mask(mask), .clear(clear),
        .snapshot_req(req), .snapshot_ready(ready), .snapshot_valid(v2), .snapshot_overrun(o2),
        .counters(c2), .snapshot(s2), .overflow_flags(f2), .snapshot_overflow(sf2)
`ifdef PERF_COUNTER_THRESHOLD_IRQ_EN
        , .threshold(thr4), .threshold_hit(hit2)
`endif
    );

    function automatic logic [31:0] act_cnt(int k, int i);
        case (k)
            0:       return {24'b0, c0[i]};
            1:       return {28'b0, c1[i]};
            default: return {28'b0, c2[i]};
        endcase
    endfunction

    function automatic logic [31:0] act_snap(int k, int i);
        case (k)
            0:       return {24'b0, s0[i]};
            1:       return {28'b0, s1[i]};
            default: return {28'b0, s2[i]};
        endcase
    endfunction

    function automatic logic [2:0] act_flags(int k);
        return (k == 0) ? f0 : (k == 1) ? f1 : f2;
    endfunction

    function automatic logic [2:0] act_sflags(int k);
        return (k == 0) ? sf0 : (k == 1) ? sf1 : sf2;
    endfunction

    function automatic logic act_valid(int k);
        return (k == 0) ? v0 : (k == 1) ? v1 : v2;
    endfunction

    function automatic logic act_ovr(int k);
        return (k == 0) ? o0 : (k == 1) ? o1 : o2;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < 3; i++) begin
                m_cnt[k][i]  = 0;
                m_snap[k][i] = 0;
            end
            m_ovf[k]   = '0;
            m_sovf[k]  = '0;
            m_valid[k] = 1'b0;
            m_ovr[k]   = 1'b0;
        end
`ifdef PERF_COUNTER_THRESHOLD_IRQ_EN
        m_hit = '0;
`endif
    endtask

    // One clock of behaviour derived from the counting / snapshot rules.
    task automatic model_update();
        for (int k = 0; k < 3; k++) begin
            int maxv;
            bit acc;
            maxv     = (1 << cw_of[k]) - 1;
            m_ovr[k] = req && m_valid[k] && !ready && !clear;
            acc      = req && !clear && (!m_valid[k] || ready);
            for (int i = 0; i < 3; i++) begin
                int inc, base, s, newv;
                inc = !mask[i] ? 0 : (k == 0) ? int'(ev1[i]) : int'(ev3[3*i +: 3]);
                if (clear) begin
                    m_cnt[k][i] = 0;
                    m_ovf[k][i] = 1'b0;
`ifdef PERF_COUNTER_THRESHOLD_IRQ_EN
                    if (k == 0) m_hit[i] = 1'b0;
`endif
                end else begin
                    base = m_cnt[k][i];
                    if (acc) begin
                        m_snap[k][i] = m_cnt[k][i];
                        m_sovf[k][i] = m_ovf[k][i];
                        m_ovf[k][i]  = 1'b0;
                        base         = 0;
                    end
                    s = base + inc;
                    if (s > maxv) begin
                        m_ovf[k][i] = 1'b1;
                        newv = sat_of[k] ? maxv : s - (maxv + 1);
                    end else begin
                        newv = s;
                    end
`ifdef PERF_COUNTER_THRESHOLD_IRQ_EN
                    if (k == 0) m_hit[i] = !acc && (m_thr != 0) && (m_cnt[k][i] < m_thr) && (newv >= m_thr);
`endif
                    m_cnt[k][i] = newv;
                end
            end
            if (!clear) begin
                if (acc) m_valid[k] = 1'b1;
                else if (ready) m_valid[k] = 1'b0;
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        if (rst) model_reset();
        else model_update();
        #1;
    endtask

    task automatic idle_inputs();
        ev1 = '0; ev3 = '0; clear = 1'b0; req = 1'b0; ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; mask = 3'b111;
        idle_inputs();
        step();
        step();
        for (int i = 0; i < 3; i++) begin
            n_chk++; if (c0[i] !== 8'd0) begin n_fail++; $display("FAIL reset_cnt ch%0d: got %0d want 0", i, c0[i]); end
            n_chk++; if (s2[i] !== 4'd0) begin n_fail++; $display("FAIL reset_snap ch%0d: got %0d want 0", i, s2[i]); end
        end
        n_chk++; if ({v0, o0, f0, sf0} !== 8'd0) begin n_fail++; $display("FAIL reset_ctrl: got %b want 0", {v0, o0, f0, sf0}); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_bitmap();
        logic [2:0] pat [5] = '{3'b001, 3'b101, 3'b001, 3'b011, 3'b101};
        mask = 3'b111;
        for (int p = 0; p < 5; p++) begin
            ev1 = pat[p];
            step();
        end
        ev1 = '0;
        n_chk++; if (c0[0] !== 8'd5) begin n_fail++; $display("FAIL bitmap ch0: got %0d want 5", c0[0]); end
        n_chk++; if (c0[1] !== 8'd1) begin n_fail++; $display("FAIL bitmap ch1: got %0d want 1", c0[1]); end
        n_chk++; if (c0[2] !== 8'd2) begin n_fail++; $display("FAIL bitmap ch2: got %0d want 2", c0[2]); end
        n_chk++; if (f0 !== 3'b000) begin n_fail++; $display("FAIL bitmap flags: got %b want 000", f0); end
    endtask

    task automatic test_wrap_sat();
        clear = 1'b1; step(); clear = 1'b0;
        ev3 = 9'd7;
        step(); step();
        n_chk++; if (c1[0] !== 4'd14 || c2[0] !== 4'd14) begin n_fail++; $display("FAIL preload14: got %0d/%0d want 14/14", c1[0], c2[0]); end
        ev3 = 9'd3;
        step();
        n_chk++; if (c1[0] !== 4'd1 || f1[0] !== 1'b1) begin n_fail++; $display("FAIL wrap: got %0d flag %b want 1 flag 1", c1[0], f1[0]); end
        n_chk++; if (c2[0] !== 4'd15 || f2[0] !== 1'b1) begin n_fail++; $display("FAIL sat: got %0d flag %b want 15 flag 1", c2[0], f2[0]); end
        step();
        n_chk++; if (c2[0] !== 4'd15 || f2[0] !== 1'b1) begin n_fail++; $display("FAIL sat_hold: got %0d flag %b want 15 flag 1", c2[0], f2[0]); end
        n_chk++; if (c1[0] !== 4'd4 || f1[0] !== 1'b1) begin n_fail++; $display("FAIL wrap_sticky: got %0d flag %b want 4 flag 1", c1[0], f1[0]); end
        ev3 = '0;
    endtask

    task automatic test_snapshot();
        clear = 1'b1; step(); clear = 1'b0;
        ev1 = 3'b001;
        repeat (9) step();
        n_chk++; if (c0[0] !== 8'd9) begin n_fail++; $display("FAIL pre_snap: got %0d want 9", c0[0]); end
        req = 1'b1;
        step();
        req = 1'b0; ev1 = '0;
        n_chk++; if (s0[0] !== 8'd9) begin n_fail++; $display("FAIL snap_val: got %0d want 9", s0[0]); end
        n_chk++; if (c0[0] !== 8'd1) begin n_fail++; $display("FAIL snap_carry_in: got %0d want 1", c0[0]); end
        n_chk++; if (v0 !== 1'b1) begin n_fail++; $display("FAIL snap_valid: got %b want 1", v0); end
    endtask

    task automatic test_overrun_handshake();
        req = 1'b1; ready = 1'b0; ev1 = 3'b001;
        step();
        req = 1'b0; ev1 = '0;
        n_chk++; if (o0 !== 1'b1) begin n_fail++; $display("FAIL overrun_pulse: got %b want 1", o0); end
        n_chk++; if (s0[0] !== 8'd9 || v0 !== 1'b1) begin n_fail++; $display("FAIL overrun_hold: got %0d v%b want 9 v1", s0[0], v0); end
        n_chk++; if (c0[0] !== 8'd2) begin n_fail++; $display("FAIL overrun_count: got %0d want 2", c0[0]); end
        step();
        n_chk++; if (o0 !== 1'b0) begin n_fail++; $display("FAIL overrun_single: got %b want 0", o0); end
        ready = 1'b1;
        step();
        ready = 1'b0;
        n_chk++; if (v0 !== 1'b0) begin n_fail++; $display("FAIL consume: got %b want 0", v0); end
        req = 1'b1;
        step();
        n_chk++; if (s0[0] !== 8'd2 || c0[0] !== 8'd0) begin n_fail++; $display("FAIL resnap: got %0d/%0d want 2/0", s0[0], c0[0]); end
        ready = 1'b1; ev1 = 3'b001;
        step();
        req = 1'b0; ready = 1'b0; ev1 = '0;
        n_chk++; if (v0 !== 1'b1 || s0[0] !== 8'd0 || c0[0] !== 8'd1) begin n_fail++; $display("FAIL req_ready: got v%b %0d/%0d want v1 0/1", v0, s0[0], c0[0]); end
    endtask

    task automatic test_clear();
        ev1 = 3'b111; ev3 = 9'h1FF;
        repeat (3) step();
        n_chk++; if (f1 !== 3'b111) begin n_fail++; $display("FAIL pre_clear_flags: got %b want 111", f1); end
        clear = 1'b1;
        step();
        clear = 1'b0; ev1 = '0; ev3 = '0;
        n_chk++; if (c0[0] !== 8'd0 || c0[1] !== 8'd0 || c0[2] !== 8'd0) begin n_fail++; $display("FAIL clear_cnt: got %0d %0d %0d want 0", c0[0], c0[1], c0[2]); end
        n_chk++; if (f1 !== 3'b000 || c1[2] !== 4'd0) begin n_fail++; $display("FAIL clear_flags: got %b/%0d want 000/0", f1, c1[2]); end
        n_chk++; if (32'(s0[0]) !== 32'(m_snap[0][0]) || v0 !== 1'b1) begin n_fail++; $display("FAIL clear_keeps_snap: got %0d v%b want %0d v1", s0[0], v0, m_snap[0][0]); end
    endtask

    task automatic test_async_reset();
        ev1 = 3'b111;
        repeat (3) step();
        #2 rst = 1'b1;
        #1;
        n_chk++; if ({c0[0], c0[1], c0[2]} !== 24'd0 || {v0, o0, f0, sf0} !== 8'd0 || s0[0] !== 8'd0) begin
            n_fail++; $display("FAIL async_reset: got %0d %0d %0d ctrl %b want 0", c0[0], c0[1], c0[2], {v0, o0, f0, sf0});
        end
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        ev1 = 3'b001;
        step();
        ev1 = '0;
        n_chk++; if (c0[0] !== 8'd1 || c0[1] !== 8'd0) begin n_fail++; $display("FAIL resume: got %0d/%0d want 1/0", c0[0], c0[1]); end
    endtask

`ifdef PERF_COUNTER_THRESHOLD_IRQ_EN
    task automatic test_threshold();
        clear = 1'b1; step(); clear = 1'b0;
        ev1 = 3'b010;
        repeat (4) step();
        n_chk++; if (c0[1] !== 8'd4 || hit0 !== 3'b000) begin n_fail++; $display("FAIL thr_below: got %0d hit %b want 4 hit 000", c0[1], hit0); end
        step();
        n_chk++; if (c0[1] !== 8'd5 || hit0 !== 3'b010) begin n_fail++; $display("FAIL thr_cross: got %0d hit %b want 5 hit 010", c0[1], hit0); end
        step();
        ev1 = '0;
        n_chk++; if (hit0 !== 3'b000) begin n_fail++; $display("FAIL thr_once: got %b want 000", hit0); end
    endtask
`endif

    task automatic test_random();
        for (int cyc = 0; cyc < 400; cyc++) begin
            ev1   = 3'($urandom);
            ev3   = 9'($urandom);
            mask  = 3'($urandom);
            clear = ($urandom_range(0, 24) == 0);
            req   = ($urandom_range(0, 3) == 0);
            ready = 1'($urandom);
            step();
            for (int k = 0; k < 3; k++) begin
                for (int i = 0; i < 3; i++) begin
                    n_chk++;
                    if (act_cnt(k, i) !== 32'(m_cnt[k][i])) begin
                        n_fail++; $display("FAIL rnd_cnt c%0d b%0d ch%0d: got %0d want %0d", cyc, k, i, act_cnt(k, i), m_cnt[k][i]);
                    end
                    n_chk++;
                    if (act_snap(k, i) !== 32'(m_snap[k][i])) begin
                        n_fail++; $display("FAIL rnd_snap c%0d b%0d ch%0d: got %0d want %0d", cyc, k, i, act_snap(k, i), m_snap[k][i]);
                    end
                end
                n_chk++;
                if ({act_flags(k), act_sflags(k), act_valid(k), act_ovr(k)} !== {m_ovf[k], m_sovf[k], m_valid[k], m_ovr[k]}) begin
                    n_fail++; $display("FAIL rnd_ctrl c%0d b%0d: got %b want %b", cyc, k,
                        {act_flags(k), act_sflags(k), act_valid(k), act_ovr(k)}, {m_ovf[k], m_sovf[k], m_valid[k], m_ovr[k]});
                end
            end
`ifdef PERF_COUNTER_THRESHOLD_IRQ_EN
            n_chk++; if (hit0 !== m_hit) begin n_fail++; $display("FAIL rnd_hit c%0d: got %b want %b", cyc, hit0, m_hit); end
`endif
        end
        idle_inputs();
    endtask

    initial begin
`ifdef PERF_COUNTER_THRESHOLD_IRQ_EN
        thr  = 8'(m_thr);
        thr4 = 4'd0;
`endif
        test_reset();
        test_bitmap();
        test_wrap_sat();
        test_snapshot();
        test_overrun_handshake();
        test_clear();
        test_async_reset();
`ifdef PERF_COUNTER_THRESHOLD_IRQ_EN
        test_threshold();
`endif
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/perf_event_counter_bank.md
Name: perf_event_counter_bank

Overview:
Parametrised successor to the per-event counter bank in the continuous monitoring system. It keeps N independent counters, one per performance event channel. Each counter adds a multi-bit increment per cycle, selectable wrap or saturate, with sticky overflow flags. An atomic snapshot-and-clear with a valid/ready handoff lets the host/trace path read interval counts without losing any events.

Parameters:
NO_OF_EVENTS, 3, number of event channels (N)
COUNTER_WIDTH, 8, width of each live and snapshot counter
INC_WIDTH, 1, per-channel increment width; 1 gives plain event-bitmap behaviour
SATURATE, 0, 0 = counters wrap modulo 2^COUNTER_WIDTH; 1 = counters clamp at all-ones

Ports:
clk  in  1  sole clock, rising edge
rst  in  1  asynchronous, active-high reset
event_increments  in  N*INC_WIDTH  packed increment per channel; channel i is [i*INC_WIDTH +: INC_WIDTH]
enable_mask  in  N  channel i counts only when bit i = 1
clear  in  1  synchronous clear of live counters and overflow flags
snapshot_req  in  1  single-cycle request to snapshot and clear
snapshot_ready  in  1  consumer accepts snapshot
snapshot_valid  out  1  snapshot registers hold unconsumed data
snapshot_overrun  out  1  one-cycle pulse when a request is dropped
counters  out  [COUNTER_WIDTH-1:0] x N (unpacked)  live counters
snapshot  out  [COUNTER_WIDTH-1:0] x N (unpacked)  captured counters
overflow_flags  out  N  sticky live-interval overflow per channel
snapshot_overflow  out  N  overflow flags captured with the snapshot

Behaviour:
- Reset (async, rst=1): all counters, snapshot, overflow_flags, snapshot_overflow, snapshot_valid and snapshot_overrun = 0.
- Per-cycle priority: rst > clear > accepted snapshot > count.
- Count:
  - inc_i = enable_mask[i] ? event_increments[i] : 0.
  - counters[i] <= counters[i] + inc_i; visible one cycle after the event is sampled.
  - Sum is computed at COUNTER_WIDTH+1 bits. If the carry is set, overflow_flags[i] <= 1 (sticky).
  - SATURATE=1: counter result = all-ones on carry. SATURATE=0: result = low COUNTER_WIDTH bits.
- Clear: counters and overflow_flags <= 0. That cycle's increments are discarded. Snapshot registers and snapshot_valid are untouched. A snapshot_req in the same cycle is ignored, with no overrun pulse.
- Snapshot accept condition: snapshot_req && (!snapshot_valid || snapshot_ready).
- On accept:
  - snapshot[i] <= pre-increment counters[i]; snapshot_overflow <= overflow_flags.
  - counters[i] <= inc_i, so no event is lost. overflow_flags[i] <= 0, and is set only if inc_i alone overflows, which is impossible when INC_WIDTH <= COUNTER_WIDTH.
  - snapshot_valid <= 1.
- Handshake:
  - snapshot_valid && snapshot_ready with no accepted request -> snapshot_valid <= 0.
  - Snapshot contents hold stable while snapshot_valid=1.
- Overrun: snapshot_req && snapshot_valid && !snapshot_ready -> request dropped, snapshot_overrun=1 for exactly one cycle, live counting continues.
- Width rule: INC_WIDTH <= COUNTER_WIDTH is required, checked by elaboration-time assertion.

Optional Feature:
PERF_COUNTER_THRESHOLD_IRQ_EN
- Defined:
  - Adds input threshold [COUNTER_WIDTH-1:0] and output threshold_hit [N-1:0].
  - threshold_hit[i] pulses for one cycle, registered, on the cycle the new counters[i] value first becomes >= threshold when the previous value was < threshold.
  - No pulse on clear, snapshot, or wrap back below threshold.
  - threshold=0 never fires.
- Undefined: ports and logic are absent; all other behaviour is identical.

Decomposition:
- continuous_monitoring_system_pkg gains:
  - PERFORMANCE_EVENT_INC_WIDTH constant.
  - Typedef perf_counter_t = logic [PERFORMANCE_EVENT_MOD_COUNTER_WIDTH-1:0].
  - Reuse of the existing NO_OF_PERFORMANCE_EVENTS and PERFORMANCE_EVENT_MOD_COUNTER_WIDTH as top-level defaults.
- Sub-module perf_counter_channel: one counter with add, wrap/saturate, overflow flag, load-on-snapshot and optional threshold detect. It is instantiated N times by a generate loop.
- The top keeps only the snapshot handshake and overrun logic.

Test Plan:
- Bitmap counting (N=3, INC_WIDTH=1, COUNTER_WIDTH=8, mask=111): apply 'b001,'b101,'b001,'b011,'b101 -> counters = {2,1,5} for channels {2,1,0}, overflow_flags=0.
- Wrap vs saturate (COUNTER_WIDTH=4, INC_WIDTH=3): ch0 at 14, inc 3:
  - SATURATE=0 -> 1, overflow_flags[0]=1.
  - SATURATE=1 -> 15, flag=1.
  - Further incs keep 15 and the flag stays set.
- Snapshot and clear: counters[0]=9, snapshot_req with inc_0=1 that cycle -> next cycle snapshot[0]=9, counters[0]=1, snapshot_valid=1.
- Overrun and handshake:
  - Second snapshot_req while valid and ready=0 -> snapshot_overrun pulses 1 cycle, snapshot unchanged.
  - ready=1 -> valid drops next cycle.
  - req together with ready=1 -> new snapshot loaded, valid stays 1.
- Clear and async reset mid-count:
  - clear=1 with events -> counters=0, flags=0, snapshot retained.
  - rst asserted between clock edges -> all outputs 0 immediately, counting resumes from 0 after release.
- Threshold (PERF_COUNTER_THRESHOLD_IRQ_EN, threshold=5): ch1 counts 4->5 -> threshold_hit[1] one-cycle pulse; 5->6 -> no pulse.
